cdb_arbiter: RTL and testbench

Shares the 4-bit common data bus (CDB) between the functional units that produce results for the out-of-order core. Each source pushes tagged results into a private 2-entry queue. A round-robin arbiter drains one result per cycle onto a registered CDB broadcast (valid/tag/data/source). The CDB broadcast feeds the reservation stations and register file, and the core's top level exports cdb_data to the output pins.

---
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source 2-entry result queues drained round-robin
// onto a registered broadcast of one result per cycle.
module cdb_arbiter #(
    parameter  int unsigned NUM_SRC = 3,
    parameter  int unsigned TAG_W   = 3,
    parameter  int unsigned DATA_W  = 4,
    parameter  int unsigned DEPTH   = 2,
    localparam int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    output logic                      cdb_valid_o,
    output logic [TAG_W-1:0]          cdb_tag_o,
    output logic [DATA_W-1:0]         cdb_data_o,
    output logic [SRC_W-1:0]          cdb_src_o
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned LAST_SRC = NUM_SRC - 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             head_q [NUM_SRC];
    entry_t             head_d [NUM_SRC];
    entry_t             tail_q [NUM_SRC];
    entry_t             tail_d [NUM_SRC];
    entry_t             in_ent [NUM_SRC];
    logic [CNT_W-1:0]   cnt_q  [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d  [NUM_SRC];
    logic [NUM_SRC-1:0] ready_q, ready_d;
    logic [NUM_SRC-1:0] push, pop;
    logic [SRC_W-1:0]   ptr_q, ptr_d;

    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    logic               grant_vld;
    logic [SRC_W-1:0]   grant_idx;

    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base,
                                                input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        return SRC_W'(sum % NUM_SRC);
    endfunction

    // First non-empty queue at or after the round-robin pointer wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!grant_vld && (cnt_q[rr_idx(ptr_q, k)] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = rr_idx(ptr_q, k);
            end
        end
    end

    // Queue, pointer and broadcast next-state
    always_comb begin
        ptr_d       = ptr_q;
        cdb_valid_d = grant_vld;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        push        = '0;
        pop         = '0;
        ready_d     = '0;

        if (grant_vld) begin
            cdb_tag_d  = head_q[grant_idx].tag;
            cdb_data_d = head_q[grant_idx].data;
            cdb_src_d  = grant_idx;
            ptr_d      = (grant_idx == SRC_W'(LAST_SRC)) ? '0 : grant_idx + SRC_W'(1);
        end

        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            in_ent[i].tag  = src_tag_i[i*TAG_W +: TAG_W];
            in_ent[i].data = src_data_i[i*DATA_W +: DATA_W];
            push[i]        = src_valid_i[i] & ready_q[i];
            pop[i]         = grant_vld && (grant_idx == SRC_W'(i));
            head_d[i]      = head_q[i];
            tail_d[i]      = tail_q[i];
            cnt_d[i]       = cnt_q[i];

            // Pop shifts the tail forward; a push then lands in the first free slot
            if (pop[i]) begin
                head_d[i] = tail_q[i];
                cnt_d[i]  = cnt_q[i] - CNT_W'(1);
            end
            if (push[i]) begin
                if (cnt_d[i] == '0) begin
                    head_d[i] = in_ent[i];
                end else begin
                    tail_d[i] = in_ent[i];
                end
                cnt_d[i] = cnt_d[i] + CNT_W'(1);
            end

            if (flush_i) begin
                cnt_d[i] = '0;
            end
            ready_d[i] = (cnt_d[i] != CNT_W'(DEPTH));
        end

        if (flush_i) begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = cdb_tag_q;
            cdb_data_d  = cdb_data_q;
            cdb_src_d   = cdb_src_q;
            ptr_d       = ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                cnt_q[i]  <= '0;
                head_q[i] <= '0;
                tail_q[i] <= '0;
            end
            ready_q     <= '1;
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            ready_q     <= ready_d;
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign src_ready_o = ready_q;
    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand sequences for backpressure,
// fairness and flush, then random traffic against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int TW = 3;
    localparam int DW = 4;
    localparam int SW = 2;
    localparam int QD = 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [N-1:0]    src_valid_i = '0;
    logic [N-1:0]    src_ready_o;
    logic [N*TW-1:0] src_tag_i = '0;
    logic [N*DW-1:0] src_data_i = '0;
    logic            cdb_valid_o;
    logic [TW-1:0]   cdb_tag_o;
    logic [DW-1:0]   cdb_data_o;
    logic [SW-1:0]   cdb_src_o;

    cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW), .DEPTH(QD)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .src_valid_i(src_valid_i),
        .src_ready_o(src_ready_o),
        .src_tag_i  (src_tag_i),
        .src_data_i (src_data_i),
        .cdb_valid_o(cdb_valid_o),
        .cdb_tag_o  (cdb_tag_o),
        .cdb_data_o (cdb_data_o),
        .cdb_src_o  (cdb_src_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one FIFO of {tag,data} per source plus a pointer
    logic [TW+DW-1:0] mq [N][$];
    int               m_ptr   = 0;
    logic             m_valid = 1'b0;
    int               m_tag   = 0;
    int               m_data  = 0;
    int               m_src   = 0;

    typedef struct {
        logic            rst;
        logic            flush;
        logic [N-1:0]    valid;
        logic [N*TW-1:0] tag;
        logic [N*DW-1:0] data;
        logic            ev;
        logic [TW-1:0]   et;
        logic [DW-1:0]   ed;
        logic [SW-1:0]   es;
        logic [N-1:0]    er;
    } vec_t;

    vec_t tbl [14];

    logic [TW-1:0] s2_tag [3] = '{3'd5, 3'd6, 3'd7};
    logic [DW-1:0] s2_dat [3] = '{4'h5, 4'hC, 4'h3};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() != QD);
        return r;
    endfunction

    task automatic model_step(input logic r, input logic f, input logic [N-1:0] v,
                              input logic [N*TW-1:0] t, input logic [N*DW-1:0] d);
        int win;
        int j;
        bit rdy [N];
        logic [TW+DW-1:0] e;
        if (r) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_ptr = 0; m_valid = 1'b0; m_tag = 0; m_data = 0; m_src = 0;
            return;
        end
        for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < QD);
        win = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (win < 0 && mq[j].size() > 0) win = j;
        end
        if (f) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0;
            return;
        end
        if (win >= 0) begin
            e       = mq[win].pop_front();
            m_valid = 1'b1;
            m_tag   = int'(e[TW+DW-1:DW]);
            m_data  = int'(e[DW-1:0]);
            m_src   = win;
            m_ptr   = (win + 1) % N;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (v[i] && rdy[i]) mq[i].push_back({t[i*TW +: TW], d[i*DW +: DW]});
    endtask

    task automatic step(input logic r, input logic f, input logic [N-1:0] v,
                        input logic [N*TW-1:0] t, input logic [N*DW-1:0] d);
        rst_i = r; flush_i = f; src_valid_i = v; src_tag_i = t; src_data_i = d;
        model_step(r, f, v, t, d);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_model(input string name);
        chk({name, "_valid"}, 32'(cdb_valid_o), 32'(m_valid));
        if (m_valid) begin
            chk({name, "_tag"},  32'(cdb_tag_o),  m_tag);
            chk({name, "_data"}, 32'(cdb_data_o), m_data);
            chk({name, "_src"},  32'(cdb_src_o),  m_src);
        end
        chk({name, "_ready"}, 32'(src_ready_o), 32'(model_ready()));
    endtask

    initial begin
        logic [N-1:0]    v;
        logic [N*TW-1:0] t;
        logic [N*DW-1:0] d;
        int              s2i;
        int              got [$];
        int              last;
        bit              acc;

        // Directed vectors: reset, single result, three-way push from pointer 0
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 9'h000, 12'h000, 1'b0, 3'd0, 4'h0, 2'd0, 3'b111};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 9'h000, 12'h000, 1'b0, 3'd0, 4'h0, 2'd0, 3'b111};
        tbl[2]  = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b0, 3'd0, 4'h0, 2'd0, 3'b111};
        tbl[3]  = '{1'b0, 1'b0, 3'b010, 9'h028, 12'h0A0, 1'b0, 3'd0, 4'h0, 2'd0, 3'b111};
        tbl[4]  = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b1, 3'd5, 4'hA, 2'd1, 3'b111};
        tbl[5]  = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b0, 3'd5, 4'hA, 2'd1, 3'b111};
        tbl[6]  = '{1'b0, 1'b0, 3'b100, 9'h100, 12'h700, 1'b0, 3'd5, 4'hA, 2'd1, 3'b111};
        tbl[7]  = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b1, 3'd4, 4'h7, 2'd2, 3'b111};
        tbl[8]  = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b0, 3'd4, 4'h7, 2'd2, 3'b111};
        tbl[9]  = '{1'b0, 1'b0, 3'b111, 9'h0D1, 12'h321, 1'b0, 3'd4, 4'h7, 2'd2, 3'b111};
        tbl[10] = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b1, 3'd1, 4'h1, 2'd0, 3'b111};
        tbl[11] = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b1, 3'd2, 4'h2, 2'd1, 3'b111};
        tbl[12] = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b1, 3'd3, 4'h3, 2'd2, 3'b111};
        tbl[13] = '{1'b0, 1'b0, 3'b000, 9'h000, 12'h000, 1'b0, 3'd3, 4'h3, 2'd2, 3'b111};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].tag, tbl[i].data);
            chk($sformatf("vec%0d_valid", i), 32'(cdb_valid_o), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_tag", i),   32'(cdb_tag_o),   32'(tbl[i].et));
            chk($sformatf("vec%0d_data", i),  32'(cdb_data_o),  32'(tbl[i].ed));
            chk($sformatf("vec%0d_src", i),   32'(cdb_src_o),   32'(tbl[i].es));
            chk($sformatf("vec%0d_ready", i), 32'(src_ready_o), 32'(tbl[i].er));
        end

        // Backpressure: S0/S1 keep the arbiter busy while S2 holds its third result
        s2i = 0;
        for (int c = 0; c < 20; c++) begin
            v = '0; t = '0; d = '0;
            if (c < 2) begin
                v[1:0] = 2'b11;
                t[5:0] = {3'(c + 2), 3'(c + 1)};
                d[7:0] = {4'(c + 8), 4'(c + 4)};
            end
            if (s2i < 3) begin
                v[2]    = 1'b1;
                t[8:6]  = s2_tag[s2i];
                d[11:8] = s2_dat[s2i];
            end
            acc = v[2] && (mq[2].size() < QD);
            step(1'b0, 1'b0, v, t, d);
            if (acc) s2i++;
            check_model("bp");
            if (c == 1) chk("bp_ready2_full", 32'(src_ready_o[2]), 0);
            if (cdb_valid_o && cdb_src_o == 2'd2) got.push_back(int'(cdb_tag_o));
        end
        chk("bp_s2_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++)
            chk($sformatf("bp_s2_order%0d", i), got[i], int'(s2_tag[i]));

        // Fairness: every source refills whenever it has room
        last = -1;
        for (int c = 0; c < 16; c++) begin
            v = model_ready();
            t = N*TW'($urandom);
            d = N*DW'($urandom);
            step(1'b0, 1'b0, v, t, d);
            check_model("rr");
            if (c >= 4) begin
                chk("rr_busy", 32'(cdb_valid_o), 1);
                if (last >= 0) chk("rr_rotate", 32'(cdb_src_o), (last + 1) % N);
                last = int'(cdb_src_o);
            end
        end

        // Flush mid-stream with S0/S1 loaded and an S2 push in the flush cycle
        for (int c = 0; c < 3; c++) begin
            v = model_ready() & 3'b011;
            step(1'b0, 1'b0, v, 9'h0ED, 12'hBEE);
            check_model("fl_fill");
        end
        step(1'b0, 1'b1, 3'b111, 9'h1FF, 12'hFFF);
        chk("fl_valid", 32'(cdb_valid_o), 0);
        chk("fl_ready", 32'(src_ready_o), 32'(3'b111));
        check_model("fl");
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 3'b000, 9'h000, 12'h000);
            chk("fl_no_stale", 32'(cdb_valid_o), 0);
        end
        step(1'b0, 1'b0, 3'b100, 9'h180, 12'h900);
        chk("fl_fresh_wait", 32'(cdb_valid_o), 0);
        step(1'b0, 1'b0, 3'b000, 9'h000, 12'h000);
        chk("fl_fresh_valid", 32'(cdb_valid_o), 1);
        chk("fl_fresh_tag",   32'(cdb_tag_o),   6);
        chk("fl_fresh_data",  32'(cdb_data_o),  9);
        chk("fl_fresh_src",   32'(cdb_src_o),   2);

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 3),
                 N'($urandom), (N*TW)'($urandom), (N*DW)'($urandom));
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
